// File: rtl/sig_smooth_pkg.sv
// sig_smooth_pkg: shared constants for the moving-average front end.
//   SAT_CODE_DEF    reserved output code marking an overrange sample
//   WIN_LOG_MAX_DEF largest window exponent (window = 2^exp samples)
//   RING_DEPTH      sample history depth, 2^WIN_LOG_MAX_DEF
//   DATA_W / SUM_W  sample width and running-sum width (16 x 16'hffff fits in 20 bits)
package sig_smooth_pkg;
  localparam int          DATA_W          = 16;
  localparam logic [15:0] SAT_CODE_DEF    = 16'hfff0;
  localparam int          WIN_LOG_MAX_DEF = 4;
  localparam int          RING_DEPTH      = 2 ** WIN_LOG_MAX_DEF;
  localparam int          SUM_W           = DATA_W + WIN_LOG_MAX_DEF;
endpackage

// File: rtl/sig_smooth_ring.sv
// sm_ring: sample-history register file, one write port, one
// asynchronous read port.
//   clk_sys  system clock
//   we       write enable
//   wr_addr  write index (the top's wr_ptr)
//   wr_data  baseline-corrected sample to store
//   rd_addr  read index (wr_ptr - N, the sample leaving the window)
//   rd_data  stored sample at rd_addr
// The contents are deliberately not reset: the fill counter keeps
// stale entries out of the running sum.
module sm_ring
  import sig_smooth_pkg::*;
#(
  parameter int ADDR_W = WIN_LOG_MAX_DEF
) (
  input  logic              clk_sys,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_sys) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sig_smooth.sv
// sig_smooth: baseline subtraction plus power-of-two moving average.
//   clk_sys      system clock, rising edge
//   rst_n        asynchronous active-low reset
//   adc_data     raw unsigned ADC sample
//   adc_vld      strobe qualifying adc_data
//   cfg_base     baseline subtracted from each sample (floored at 0)
//   cfg_win      window exponent, N = 2^min(cfg_win, WIN_LOG_MAX)
//   sm_data      smoothed sample, SAT_CODE when overrange
//   sm_vld       strobe qualifying sm_data
//   stu_fill     high while the window is (re)filling
//   stu_sat_cnt  saturating count of overrange input samples
// Handshake: adc_vld and sm_vld are single-cycle valid strobes with no
// ready; every valid input is taken, and once the window is full every
// sample yields exactly one sm_vld two clock edges after it is sampled.
module sig_smooth
  import sig_smooth_pkg::*;
#(
  parameter logic [15:0] SAT_CODE    = SAT_CODE_DEF,
  parameter int          WIN_LOG_MAX = WIN_LOG_MAX_DEF
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [15:0] adc_data,
  input  logic        adc_vld,
  input  logic [15:0] cfg_base,
  input  logic [2:0]  cfg_win,
  output logic [15:0] sm_data,
  output logic        sm_vld,
  output logic        stu_fill,
  output logic [15:0] stu_sat_cnt
);
  localparam int           PTR_W   = WIN_LOG_MAX;
  localparam int           SW      = DATA_W + WIN_LOG_MAX;
  localparam logic [2:0]   WIN_CAP = 3'(WIN_LOG_MAX);
  localparam logic [PTR_W:0]   FILL_ONE = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  // stage 1
  logic [15:0] s1_data;
  logic        s1_sat;
  logic        s1_vld;

  // window configuration and flush
  logic [2:0]  win_q;
  logic        flush_q;

  // stage 2 state
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   fill_cnt;
  logic [SW-1:0]    sum;

  // stage 2 combinational
  logic [2:0]       win_log;
  logic [PTR_W:0]   win_n;
  logic [PTR_W-1:0] rd_ptr;
  logic [15:0]      rd_data;
  logic             full;
  logic             take;
  logic [SW-1:0]    sub;
  logic [SW-1:0]    sum_next;
  logic [SW-1:0]    avg;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_sat  <= 1'b0;
      s1_vld  <= 1'b0;
      win_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      s1_vld  <= adc_vld;
      if (adc_vld) begin
        s1_data <= (adc_data > cfg_base) ? adc_data - cfg_base : '0;
        s1_sat  <= (adc_data >= SAT_CODE);
      end
      // A change is seen here; the flush acts on the following edge,
      // by which time win_q already holds the new window.
      win_q   <= cfg_win;
      flush_q <= (cfg_win != win_q);
    end
  end

  always_comb begin
    win_log  = (win_q > WIN_CAP) ? WIN_CAP : win_q;
    win_n    = FILL_ONE << win_log;
    // For the largest window this wraps onto wr_ptr itself: the oldest
    // entry is read before being overwritten on the same edge.
    rd_ptr   = wr_ptr - win_n[PTR_W-1:0];
    full     = (fill_cnt >= win_n);
    take     = s1_vld && !flush_q;
    sub      = full ? SW'(rd_data) : '0;
    sum_next = sum + SW'(s1_data) - sub;
    avg      = sum_next >> win_log;
  end

  sm_ring #(.ADDR_W(PTR_W)) u_ring (
    .clk_sys (clk_sys),
    .we      (take),
    .wr_addr (wr_ptr),
    .wr_data (s1_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      sum         <= '0;
      sm_data     <= '0;
      sm_vld      <= 1'b0;
      stu_sat_cnt <= '0;
    end else begin
      sm_vld <= 1'b0;
      if (flush_q) begin
        // Ring and pointer are kept; a sample arriving now is dropped.
        sum      <= '0;
        fill_cnt <= '0;
      end else if (s1_vld) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        sum      <= sum_next;
        fill_cnt <= full ? fill_cnt : fill_cnt + FILL_ONE;
        sm_data  <= (s1_sat || avg >= SW'(SAT_CODE)) ? SAT_CODE : avg[15:0];
        sm_vld   <= (fill_cnt + FILL_ONE >= win_n);
      end
      if (s1_vld && s1_sat && stu_sat_cnt != 16'hffff)
        stu_sat_cnt <= stu_sat_cnt + 16'd1;
    end
  end

  assign stu_fill = (fill_cnt < win_n);
endmodule

// File: tb/tb_sig_smooth.sv
module tb_sig_smooth;
  import sig_smooth_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] adc_data = '0;
  logic        adc_vld  = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [2:0]  cfg_win  = '0;
  logic [15:0] sm_data;
  logic        sm_vld;
  logic        stu_fill;
  logic [15:0] stu_sat_cnt;

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  sig_smooth dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .adc_data    (adc_data),
    .adc_vld     (adc_vld),
    .cfg_base    (cfg_base),
    .cfg_win     (cfg_win),
    .sm_data     (sm_data),
    .sm_vld      (sm_vld),
    .stu_fill    (stu_fill),
    .stu_sat_cnt (stu_sat_cnt)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the baseline-corrected samples since the last flush and
  // averages the newest N of them directly.
  logic [15:0] exp_q[$];
  int          due_q[$];
  int          hist[$];
  int          win_m = 0;

  task automatic model_push(input logic [15:0] d);
    int n, s, v;
    v = (d > cfg_base) ? int'(d) - int'(cfg_base) : 0;
    hist.push_back(v);
    if (hist.size() > 16) void'(hist.pop_front());
    n = 1 << ((win_m > 4) ? 4 : win_m);
    if (hist.size() >= n) begin
      s = 0;
      for (int k = hist.size() - n; k < hist.size(); k++) s += hist[k];
      s = s / n;
      exp_q.push_back((d >= SAT_CODE_DEF || s >= int'(SAT_CODE_DEF)) ? SAT_CODE_DEF : 16'(s));
      due_q.push_back(cyc + 2);
    end
  endtask

  // ---------------- compare process ----------------
  int          pulse_cnt = 0;
  int          sat_pulse_cnt = 0;
  logic [15:0] last_data = '0;

  always @(negedge clk_sys) begin
    if (sm_vld) begin
      pulse_cnt++;
      last_data = sm_data;
      if (sm_data == SAT_CODE_DEF) sat_pulse_cnt++;
    end
    if (!rst_n) begin
      check("rst_sm_vld", {31'd0, sm_vld}, 32'd0);
    end else if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("sm_vld_due", {31'd0, sm_vld}, 32'd1);
      check("sm_data", {16'd0, sm_data}, {16'd0, exp_q[0]});
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      check("sm_vld_idle", {31'd0, sm_vld}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [15:0] d);
    @(posedge clk_sys); #1;
    adc_data = d;
    adc_vld  = 1'b1;
    model_push(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_sys); #1;
      adc_vld = 1'b0;
    end
  endtask

  task automatic set_win(input logic [2:0] w);
    idle(3);
    cfg_win = w;
    idle(3);
    hist.delete();
    win_m = int'(w);
  endtask

  // ---------------- directed stimulus ----------------
  int p0;

  initial begin
    // reset state
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_sm_data", {16'd0, sm_data}, 32'd0);
    check("rst_stu_fill", {31'd0, stu_fill}, 32'd1);
    check("rst_sat_cnt", {16'd0, stu_sat_cnt}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    // basic average, window 4, baseline 100
    set_win(3'd2);
    cfg_base = 16'd100;
    p0 = pulse_cnt;
    put(16'd200); put(16'd300); put(16'd400); idle(3);
    check("basic_no_out", pulse_cnt - p0, 0);
    check("basic_fill_hi", {31'd0, stu_fill}, 32'd1);
    put(16'd500); idle(3);
    check("basic_first_cnt", pulse_cnt - p0, 1);
    check("basic_first", {16'd0, last_data}, 32'd250);
    check("basic_fill_lo", {31'd0, stu_fill}, 32'd0);
    put(16'd600); idle(3);
    check("basic_second", {16'd0, last_data}, 32'd350);

    // baseline floor, window 1
    set_win(3'd0);
    p0 = pulse_cnt;
    put(16'd50); idle(1); put(16'd50); idle(1); put(16'd50); idle(3);
    check("floor_cnt", pulse_cnt - p0, 3);
    check("floor_val", {16'd0, last_data}, 32'd0);

    // overrange, window 1, baseline 0, plus code just below SAT_CODE
    cfg_base = 16'd0;
    p0 = sat_pulse_cnt;
    put(16'hfff5); put(16'hfff5); put(16'hfff5); put(16'hfff5);
    put(16'd1000); idle(3);
    check("ovr_sat_pulses", sat_pulse_cnt - p0, 4);
    check("ovr_after", {16'd0, last_data}, 32'd1000);
    check("ovr_sat_cnt", {16'd0, stu_sat_cnt}, 32'd4);
    put(16'hffef); idle(3);
    check("below_sat", {16'd0, last_data}, 32'hffef);
    check("below_sat_cnt", {16'd0, stu_sat_cnt}, 32'd4);
    // average landing in the reserved range on a non-overrange sample
    set_win(3'd1);
    put(16'hfff5); put(16'hffef); idle(3);
    check("avg_sat", {16'd0, last_data}, {16'd0, SAT_CODE_DEF});
    check("avg_sat_cnt", {16'd0, stu_sat_cnt}, 32'd5);

    // window change while streaming
    set_win(3'd2);
    put(16'd10); put(16'd20); put(16'd30); put(16'd40); put(16'd50); idle(3);
    check("win4_val", {16'd0, last_data}, 32'd35);
    check("win4_fill", {31'd0, stu_fill}, 32'd0);
    p0 = pulse_cnt;
    set_win(3'd1);
    check("flush_fill", {31'd0, stu_fill}, 32'd1);
    put(16'd7); idle(3);
    check("flush_no_out", pulse_cnt - p0, 0);
    put(16'd12); idle(3);
    check("flush_first_cnt", pulse_cnt - p0, 1);
    check("flush_first", {16'd0, last_data}, 32'd9);

    // throughput, window 16 (cfg_win 4), one sample per cycle
    set_win(3'd4);
    p0 = pulse_cnt;
    for (int i = 0; i < 64; i++) put(16'(i));
    idle(3);
    check("thru_cnt", pulse_cnt - p0, 49);
    check("thru_last", {16'd0, last_data}, 32'd55);

    // reset mid-fill
    set_win(3'd2);
    put(16'd100); put(16'd200); idle(1);
    rst_n = 1'b0;
    exp_q.delete(); due_q.delete(); hist.delete();
    #1;
    check("mid_rst_vld", {31'd0, sm_vld}, 32'd0);
    check("mid_rst_sat_cnt", {16'd0, stu_sat_cnt}, 32'd0);
    check("mid_rst_fill", {31'd0, stu_fill}, 32'd1);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    p0 = pulse_cnt;
    put(16'd40); put(16'd80); put(16'd120); idle(3);
    check("post_rst_no_out", pulse_cnt - p0, 0);
    put(16'd160); idle(3);
    check("post_rst_cnt", pulse_cnt - p0, 1);
    check("post_rst_val", {16'd0, last_data}, 32'd100);

    idle(3);
    check("exp_q_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
